c1_bus_master: RTL
==================

# c1_bus_master

Synthesizable CPU-side requester for the C1 cache bus; the parametrised successor to the behavioural CPU stimulus model. Accepts one request at a time from the core over a valid/ready handshake, and drives the command and two-beat address phase (tag+set, then offset). Drives write data or captures read data (one or two beats) and returns a single-cycle response to the core. Sits between the core pipeline and the L1 cache's C1 port.

## Interface
- `ADDR_W`, 19, byte address width.
- `BUS_W`, 16, C1 data bus width; must be ≥ 8.
- `OFFSET_W`, 4, line offset bits.
- `TIMEOUT_CYCLES`, 255, response watchdog limit; used only with the timeout feature.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: core request valid.
- `req_ready` out 1: block can accept a request.
- `req_cmd` in 3: C1 command code.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 2·BUS_W: write data.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out 2·BUS_W: read data, zero-extended.
- `rsp_err` out 1: request failed.
- `address` out ADDR_W−OFFSET_W: C1 address bus, tri-state.
- `data` inout BUS_W: C1 data bus.
- `command` inout 3: C1 command bus.

## Operation
- **States:** IDLE, ADDR_TAG, ADDR_OFF, WAIT_RSP, RD_BEAT2, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`&&`req_ready`: latch cmd, addr and wdata, then go to ADDR_TAG.
  - Exception: cmd NOP (0) skips the bus, goes straight to RESP, and sets `rsp_err` = 1.
- **ADDR_TAG**
  - Drive `command` = cmd and `address` = addr[ADDR_W−1:OFFSET_W].
  - For writes, also drive `data` = wdata[BUS_W−1:0].
- **ADDR_OFF**
  - Drive `command` = cmd and `address` = addr[OFFSET_W−1:0], zero-extended.
  - For WRITE32 (7), drive `data` = wdata[2·BUS_W−1:BUS_W]; for other writes, hold the low beat.
- **WAIT_RSP**
  - `address`, `command` and `data` are all 'z.
  - Sample `command` each edge.
  - On 3'd7: for reads, capture `data` into the low half. READ32 goes to RD_BEAT2; all others go to RESP.
- **RD_BEAT2:** capture `data` into the high half on the next edge, then go to RESP.
- **RESP**
  - `rsp_valid` = 1 for exactly one cycle, then IDLE.
  - `req_ready` stays 0 throughout RESP.
- **Read width rules:** READ8 returns bits [7:0] and zeros the rest; READ16 returns the low BUS_W bits; READ32 returns both beats.
- **INV_LINE (4):** address phase only, no data; returns `rsp_rdata` = 0.
- **Write responses:** return `rsp_rdata` = 0.
- `X` or `Z` sampled on `command` does not count as a response.

## Timing
- **Reset (`rst_n` low, asynchronous):**
  - `address`, `data` and `command` go to 'z immediately.
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, state = IDLE.
  - `req_ready` rises on the first edge after release.
- **Reset mid-transaction:** the transaction is dropped, the bus is released in the same cycle, and no response is issued.
- **Bus phase:** the master drives for exactly 2 cycles, then leaves a one-cycle minimum turnaround. The slave must not drive before the WAIT_RSP cycle.
- **Read latency:** accept edge → RESP = 3 + k cycles, where k is the number of WAIT_RSP cycles until 7 is sampled. READ32 adds 1.
- **Back-to-back:** the next accept can happen at the earliest on the cycle after RESP.
- `req_*` inputs are ignored outside IDLE.

## Configuration
- **`C1_MASTER_TIMEOUT_EN` defined:**
  - A counter runs in WAIT_RSP and RD_BEAT2 and resets when a state is entered.
  - At TIMEOUT_CYCLES it forces RESP with `rsp_err` = 1 and `rsp_rdata` = 0, and releases the bus.
  - The counter width is $clog2(TIMEOUT_CYCLES+1).
- **Macro undefined:** no counter; WAIT_RSP waits forever. `rsp_err` is set only for NOP.

## Structure
- **Package `c1_pkg`:**
  - `c1_cmd_e` enum: NOP=0, READ8=1, READ16=2, READ32=3, INV_LINE=4, WRITE8=5, WRITE16=6, WRITE32_RESP=7.
  - `is_write`/`is_read` functions.
  - `c1_master_state_e` enum.
- **Sub-module `c1_bus_drv`:** per-bus output-enable tri-state driver (value + oe → inout), instantiated for `address`, `data` and `command`.

## Test plan
- READ8 at addr 19'b0000000000_00010_0000; slave responds after 2 cycles with `data` = 16'hA5C3:
  - `address` shows 15'b00010 then 0.
  - `rsp_rdata` = 32'h000000C3 and `rsp_err` = 0, with `rsp_valid` 6 cycles after accept.
- WRITE32 with wdata 32'h1234_5678:
  - `data` = 16'h5678 in ADDR_TAG and 16'h1234 in ADDR_OFF.
  - Bus is 'z from WAIT_RSP on; response pulse follows slave RESP.
- READ32 with slave beats 16'hBEEF, 16'hCAFE → `rsp_rdata` = 32'hCAFEBEEF.
- NOP request → no bus activity; `rsp_valid` with `rsp_err` = 1 two cycles after accept.
- `rst_n` asserted during ADDR_OFF → all buses 'z in the same cycle; no `rsp_valid`; a fresh READ16 afterwards completes normally.
- With `C1_MASTER_TIMEOUT_EN` and TIMEOUT_CYCLES = 8, slave silent → `rsp_err` = 1 after 8 WAIT_RSP cycles.

Source files
------------

// File: rtl/c1_pkg.sv
// Shared types for the C1 cache-bus requester: command codes, the master FSM
// state encoding and small command-classification helpers.
package c1_pkg;

    // C1 command codes. Code 7 doubles as the slave's response code on the
    // command bus during the wait phase.
    typedef enum logic [2:0] {
        NOP          = 3'd0,
        READ8        = 3'd1,
        READ16       = 3'd2,
        READ32       = 3'd3,
        INV_LINE     = 3'd4,
        WRITE8       = 3'd5,
        WRITE16      = 3'd6,
        WRITE32_RESP = 3'd7
    } c1_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_TAG,
        ST_ADDR_OFF,
        ST_WAIT_RSP,
        ST_RD_BEAT2,
        ST_RESP
    } c1_master_state_e;

    localparam logic [2:0] C1_RESP_CODE = 3'd7;

    function automatic logic is_write(input c1_cmd_e cmd);
        return (cmd == WRITE8) || (cmd == WRITE16) || (cmd == WRITE32_RESP);
    endfunction

    function automatic logic is_read(input c1_cmd_e cmd);
        return (cmd == READ8) || (cmd == READ16) || (cmd == READ32);
    endfunction

endpackage

// File: rtl/c1_bus_drv.sv
// Output-enable tri-state driver for one C1 bus: drives the value while oe_i
// is high and releases the net to high impedance otherwise.
module c1_bus_drv #(
    parameter int W = 8
) (
    input  logic [W-1:0] val_i,
    input  logic         oe_i,
    inout  wire  [W-1:0] bus_io
);

    assign bus_io = oe_i ? val_i : {W{1'bz}};

endmodule

// File: rtl/c1_bus_master.sv
// CPU-side requester for the C1 cache bus. Accepts one core request at a time,
// runs the two-beat address phase (tag+set, then offset), drives write data or
// captures one/two read beats, and returns a one-cycle response. The response
// outputs are registered from the RESP state, so the pulse appears the cycle
// after RESP while the FSM is already back in IDLE.
// Optional feature: define C1_MASTER_TIMEOUT_EN to add a response watchdog that
// ends a silent transaction after TIMEOUT_CYCLES cycles with rsp_err set.
module c1_bus_master
    import c1_pkg::*;
#(
    parameter int ADDR_W         = 19,
    parameter int BUS_W          = 16,
    parameter int OFFSET_W       = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [2:0]             req_cmd,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [2*BUS_W-1:0]     req_wdata,
    output logic                   rsp_valid,
    output logic [2*BUS_W-1:0]     rsp_rdata,
    output logic                   rsp_err,
    output wire  [ADDR_W-OFFSET_W-1:0] address,
    inout  wire  [BUS_W-1:0]       data,
    inout  wire  [2:0]             command
);

    localparam int TAG_W = ADDR_W - OFFSET_W;

    c1_master_state_e      state_q, state_d;
    c1_cmd_e               cmd_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [2*BUS_W-1:0]    wdata_q;
    logic [2*BUS_W-1:0]    rdata_q;
    logic                  err_q;
    logic                  req_ready_q;
    logic                  rsp_valid_q;
    logic [2*BUS_W-1:0]    rsp_rdata_q;
    logic                  rsp_err_q;

    logic                  accept;
    logic                  rsp_seen;
    logic                  timeout_hit;
    logic [2*BUS_W-1:0]    rdata_shaped;

    logic [TAG_W-1:0]      addr_val;
    logic                  addr_oe;
    logic [BUS_W-1:0]      data_val;
    logic                  data_oe;
    logic [2:0]            cmd_val;
    logic                  cmd_oe;

    assign accept   = req_valid && req_ready_q;
    // A sampled X/Z never equals 7, so only a real response code counts.
    assign rsp_seen = (state_q == ST_WAIT_RSP) && (command == C1_RESP_CODE);

    // State register; async reset also releases the buses since the
    // output enables are decoded from state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples pre-edge values regardless of block ordering.
            state_q <= state_d;
        end
    end

    // Next-state and bus-drive decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case leaves a signal unassigned (which would infer a latch).
        state_d  = state_q;
        addr_oe  = 1'b0;
        addr_val = '0;
        data_oe  = 1'b0;
        data_val = '0;
        cmd_oe   = 1'b0;
        cmd_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (c1_cmd_e'(req_cmd) == NOP) ? ST_RESP : ST_ADDR_TAG;
                end
            end
            ST_ADDR_TAG: begin
                cmd_oe   = 1'b1;
                cmd_val  = cmd_q;
                addr_oe  = 1'b1;
                addr_val = addr_q[ADDR_W-1:OFFSET_W];
                if (is_write(cmd_q)) begin
                    data_oe  = 1'b1;
                    data_val = wdata_q[BUS_W-1:0];
                end
                state_d = ST_ADDR_OFF;
            end
            ST_ADDR_OFF: begin
                cmd_oe   = 1'b1;
                cmd_val  = cmd_q;
                addr_oe  = 1'b1;
                addr_val = TAG_W'(addr_q[OFFSET_W-1:0]);
                if (cmd_q == WRITE32_RESP) begin
                    data_oe  = 1'b1;
                    data_val = wdata_q[2*BUS_W-1:BUS_W];
                end else if (is_write(cmd_q)) begin
                    data_oe  = 1'b1;
                    data_val = wdata_q[BUS_W-1:0];
                end
                state_d = ST_WAIT_RSP;
            end
            ST_WAIT_RSP: begin
                if (rsp_seen) begin
                    state_d = (cmd_q == READ32) ? ST_RD_BEAT2 : ST_RESP;
                end else if (timeout_hit) begin
                    state_d = ST_RESP;
                end
            end
            ST_RD_BEAT2: state_d = ST_RESP;
            ST_RESP:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Trim captured read data to the width the command asked for.
    always_comb begin
        rdata_shaped = '0;
        case (cmd_q)
            READ8:   rdata_shaped[7:0]       = rdata_q[7:0];
            READ16:  rdata_shaped[BUS_W-1:0] = rdata_q[BUS_W-1:0];
            READ32:  rdata_shaped            = rdata_q;
            default: rdata_shaped            = '0;
        endcase
    end

    // Request latch, read-beat capture, error tracking and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q       <= NOP;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            req_ready_q <= (state_d == ST_IDLE);
            rsp_valid_q <= (state_q == ST_RESP);
            if (accept) begin
                cmd_q   <= c1_cmd_e'(req_cmd);
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rdata_q <= '0;
                err_q   <= (c1_cmd_e'(req_cmd) == NOP);
            end
            if (rsp_seen && is_read(cmd_q)) begin
                rdata_q[BUS_W-1:0] <= data;
            end
            if (state_q == ST_RD_BEAT2) begin
                rdata_q[2*BUS_W-1:BUS_W] <= data;
            end
            if (timeout_hit && !rsp_seen) begin
                err_q <= 1'b1;
            end
            if (state_q == ST_RESP) begin
                rsp_rdata_q <= err_q ? '0 : rdata_shaped;
                rsp_err_q   <= err_q;
            end
        end
    end

`ifdef C1_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt_q;

    // Fires in the last permitted cycle so the RESP entry lands after exactly
    // TIMEOUT_CYCLES cycles spent in the waiting state.
    assign timeout_hit = ((state_q == ST_WAIT_RSP) || (state_q == ST_RD_BEAT2)) &&
                         (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counter: restarts on every state entry, counts while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else if (state_d != state_q) begin
            to_cnt_q <= '0;
        end else if ((state_q == ST_WAIT_RSP) || (state_q == ST_RD_BEAT2)) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    c1_bus_drv #(.W(TAG_W)) u_addr_drv (
        .val_i  (addr_val),
        .oe_i   (addr_oe),
        .bus_io (address)
    );

    c1_bus_drv #(.W(BUS_W)) u_data_drv (
        .val_i  (data_val),
        .oe_i   (data_oe),
        .bus_io (data)
    );

    c1_bus_drv #(.W(3)) u_cmd_drv (
        .val_i  (cmd_val),
        .oe_i   (cmd_oe),
        .bus_io (command)
    );

endmodule
